dadda_mac_acc: RTL and testbench
================================

# dadda_mac_acc

Sequential multiply-accumulate stage placed directly downstream of the combinational 8x8 `dadda` multiplier. It accepts operand pairs over a valid/ready stream and registers each pair into the `dadda` instance. It sums the 16-bit products into a wide accumulator across a transaction delimited by `in_last`. It then presents the sum, the beat count and a sticky overflow flag on a valid/ready output port.

## Interface
Parameters:
- `N`, 8: operand width; fixed by `dadda`, not overridable.
- `ACC_W`, 24: accumulator width; must be ≥ 2*N.
- `CNT_W`, 8: beat-counter width.

Ports:
- `clk`, input, 1: single clock. All state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: operand pair valid.
- `in_ready`, output, 1: block can accept a pair.
- `a`, input, N: multiplicand, unsigned.
- `b`, input, N: multiplier, unsigned.
- `in_last`, input, 1: this pair ends the transaction.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer takes the result.
- `acc_out`, output, ACC_W: accumulated sum, modulo 2^ACC_W.
- `beat_cnt`, output, CNT_W: beats in the transaction, modulo 2^CNT_W.
- `overflow`, output, 1: sticky flag; set if any addition carried out of ACC_W.

## Operation
- Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- FSM states:
  - ACC: `in_ready`=1.
  - DRAIN: `in_ready`=0; the last pair is in the operand register.
  - OUT: `in_ready`=0, `out_valid`=1.
- Transitions:
  - ACC → DRAIN on an accept (`in_valid & in_ready`) with `in_last`=1.
  - DRAIN → OUT unconditionally after one cycle.
  - OUT → ACC on `out_ready`=1.
- Accepting a beat loads `a`, `b`, `in_last` into the operand register and sets `s1_valid`. `s1_valid` clears on any edge with no accept.
- Accumulate rule: every edge with `s1_valid`=1 does all of the following.
  - `acc <= acc + zero-extend(product)`, where product is the 2N-bit `dadda` output on the registered operands.
  - `beat_cnt <= beat_cnt + 1`, wrapping.
  - `overflow <= overflow | carry-out`.
- A zero product still counts as a beat.
- `acc_out`, `beat_cnt` and `overflow` drive the internal registers directly and are meaningful only while `out_valid`=1.
- Leaving OUT clears `acc`, `beat_cnt` and `overflow` to 0 in the same edge.
- `out_ready` is ignored outside OUT.
- `in_valid` with `in_ready`=0 is not a transfer; `a`, `b`, `in_last` are don't-care.
- A single-beat transaction (first beat carries `in_last`) is legal.
- Reset, including mid-transaction: state = ACC, `s1_valid`=0; `acc`, `beat_cnt`, `overflow` = 0; `out_valid`=0; `in_ready`=1 once `rst_n` deasserts. Partial sums are discarded.

## Timing
- Throughput: one beat per cycle while in ACC.
- Accept at edge k → product added at edge k+1.
- Last beat accepted at edge k → state OUT and `out_valid`=1 after edge k+1.
- Result hold: `out_valid` and the result outputs stay stable while `out_ready`=0.
- Result handoff at edge m (`out_ready`=1 in OUT):
  - `out_valid`=0 after edge m.
  - `in_ready`=1 after edge m.
  - The earliest next accept is at edge m+1.
- Back-to-back transactions therefore cost 2 dead cycles.
- Critical path: operand register → `dadda` → ACC_W adder → `acc`. No further pipelining.

## Structure
- Shared package `dadda_pkg` holds:
  - constants `DADDA_N`=8, `MAC_ACC_W`=24, `MAC_CNT_W`=8;
  - typedef `mac_state_t` {ACC, DRAIN, OUT}.
- One sub-module: the existing `dadda`, instantiated once with ports `A`, `B`, `y`.
- FSM, operand register and accumulator live in this module.

## Test plan
- Reset, handshake and single beat:
  - Assert reset → `in_ready`=1, `out_valid`=0, `acc_out`=0.
  - Then single beat a=12, b=13, last → `out_valid` one cycle after accept; `acc_out`=156, `beat_cnt`=1, `overflow`=0.
- Stream and hold:
  - 4 back-to-back beats (3×5, 7×9, 255×1, 0×200; last on the 4th) → `acc_out`=333, `beat_cnt`=4.
  - Hold `out_ready`=0 for 5 cycles → outputs stable, `in_ready`=0.
- Overflow boundary:
  - 258 beats of 255×255 → `acc_out`=16776450, `overflow`=0, `beat_cnt`=2.
  - 259 beats → `acc_out`=64259, `overflow`=1, `beat_cnt`=3.
- Input stalls: same 4-beat set with `in_valid` bubbles between beats → identical result to the stream case.
- Mid-transaction reset:
  - Pulse `rst_n` low after 2 beats → all outputs return to reset values.
  - Next transaction 2×2, last → `acc_out`=4, `beat_cnt`=1.
- Randomized self-check: 15 random transactions of 1–10 beats → `acc_out` equals the reference model sum mod 2^24 and `beat_cnt` matches; print `*ERROR*` on mismatch.

Source files
------------

// File: rtl/dadda_pkg.sv
// Shared constants, FSM state type and carry-save helpers for the dadda
// multiplier and the multiply-accumulate stage built around it.
package dadda_pkg;

  localparam int DADDA_N   = 8;
  localparam int MAC_ACC_W = 24;
  localparam int MAC_CNT_W = 8;
  localparam int PROD_W    = 2 * DADDA_N;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } mac_state_t;

  // 3:2 compressor on whole rows; the carry row is shifted into the next column.
  function automatic logic [PROD_W-1:0] csa_sum(input logic [PROD_W-1:0] x,
                                               input logic [PROD_W-1:0] y,
                                               input logic [PROD_W-1:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [PROD_W-1:0] csa_carry(input logic [PROD_W-1:0] x,
                                                 input logic [PROD_W-1:0] y,
                                                 input logic [PROD_W-1:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

endpackage

// File: rtl/dadda.sv
// Combinational 8x8 unsigned multiplier: partial-product rows reduced along the
// Dadda height sequence 8 -> 6 -> 4 -> 3 -> 2, then one carry-propagate adder.
module dadda
  import dadda_pkg::*;
(
  input  logic [DADDA_N-1:0] A,
  input  logic [DADDA_N-1:0] B,
  output logic [PROD_W-1:0]  y
);

  logic [PROD_W-1:0] pp_s [DADDA_N];
  logic [PROD_W-1:0] r6_s [6];
  logic [PROD_W-1:0] r4_s [4];
  logic [PROD_W-1:0] r3_s [3];
  logic [PROD_W-1:0] r2_s [2];

  // Partial products, each row pre-shifted to its column weight.
  always_comb begin
    for (int i = 0; i < DADDA_N; i++) begin
      pp_s[i] = {{DADDA_N{1'b0}}, (A & {DADDA_N{B[i]}})} << i;
    end
  end

  // Row reduction; modulo-2^16 arithmetic is exact since the product fits in 16 bits.
  always_comb begin
    r6_s[0] = csa_sum  (pp_s[0], pp_s[1], pp_s[2]);
    r6_s[1] = csa_carry(pp_s[0], pp_s[1], pp_s[2]);
    r6_s[2] = csa_sum  (pp_s[3], pp_s[4], pp_s[5]);
    r6_s[3] = csa_carry(pp_s[3], pp_s[4], pp_s[5]);
    r6_s[4] = pp_s[6];
    r6_s[5] = pp_s[7];

    r4_s[0] = csa_sum  (r6_s[0], r6_s[1], r6_s[2]);
    r4_s[1] = csa_carry(r6_s[0], r6_s[1], r6_s[2]);
    r4_s[2] = csa_sum  (r6_s[3], r6_s[4], r6_s[5]);
    r4_s[3] = csa_carry(r6_s[3], r6_s[4], r6_s[5]);

    r3_s[0] = csa_sum  (r4_s[0], r4_s[1], r4_s[2]);
    r3_s[1] = csa_carry(r4_s[0], r4_s[1], r4_s[2]);
    r3_s[2] = r4_s[3];

    r2_s[0] = csa_sum  (r3_s[0], r3_s[1], r3_s[2]);
    r2_s[1] = csa_carry(r3_s[0], r3_s[1], r3_s[2]);
  end

  // Final carry-propagate addition.
  always_comb begin
    y = r2_s[0] + r2_s[1];
  end

endmodule

// File: rtl/dadda_mac_acc.sv
// Multiply-accumulate stage: registers operand pairs into dadda, sums products
// across an in_last-delimited transaction and hands the result out on valid/ready.
module dadda_mac_acc
  import dadda_pkg::*;
#(
  localparam int N     = DADDA_N,
  parameter  int ACC_W = MAC_ACC_W,
  parameter  int CNT_W = MAC_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             overflow
);

  mac_state_t       state_q, state_d;
  logic             s1_valid_q, s1_valid_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic             last_q, last_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [2*N-1:0]   prod_s;
  logic [ACC_W:0]   sum_s;
  logic             accept_s;
  logic             handoff_s;

  dadda u_dadda (
    .A (a_q),
    .B (b_q),
    .y (prod_s)
  );

  // Handshake decode from the current state.
  always_comb begin
    in_ready  = (state_q == ACC);
    out_valid = (state_q == OUT);
    accept_s  = in_valid & in_ready;
    handoff_s = out_valid & out_ready;
    acc_out   = acc_q;
    beat_cnt  = cnt_q;
    overflow  = ovf_q;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC: begin
        if (accept_s && in_last) begin
          state_d = DRAIN;
        end else begin
          state_d = ACC;
        end
      end
      DRAIN: state_d = OUT;
      OUT: begin
        if (out_ready) begin
          state_d = ACC;
        end else begin
          state_d = OUT;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // Operand register and accumulator update; the ACC_W+1 sum exposes the carry-out.
  always_comb begin
    s1_valid_d = accept_s;
    a_d        = a_q;
    b_d        = b_q;
    last_d     = last_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    sum_s      = {1'b0, acc_q} + (ACC_W+1)'(prod_s);
    if (accept_s) begin
      a_d    = a;
      b_d    = b;
      last_d = in_last;
    end else begin
      last_d = last_q;
    end
    if (handoff_s) begin
      acc_d = {ACC_W{1'b0}};
      cnt_d = {CNT_W{1'b0}};
      ovf_d = 1'b0;
    end else if (s1_valid_q) begin
      acc_d = sum_s[ACC_W-1:0];
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      ovf_d = ovf_q | sum_s[ACC_W];
    end else begin
      acc_d = acc_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACC;
      s1_valid_q <= 1'b0;
      a_q        <= {N{1'b0}};
      b_q        <= {N{1'b0}};
      last_q     <= 1'b0;
      acc_q      <= {ACC_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      last_q     <= last_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_dadda_mac_acc.sv
// Self-checking bench for dadda_mac_acc against a plain-arithmetic sum model.
module tb_dadda_mac_acc;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] acc_out;
  logic [7:0]  beat_cnt;
  logic        overflow;

  int n_checks;
  int n_fail;
  int qa[$];
  int qb[$];

  dadda_mac_acc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .beat_cnt  (beat_cnt),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives every queued beat, optionally with idle bubbles; returns 0 if in_ready never came.
  task automatic drive_txn(input bit bubbles, input bit set_last, output bit ok);
    int waits;
    ok = 1'b1;
    for (int i = 0; i < qa.size(); i++) begin
      if (bubbles) begin
        int gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          tick();
        end
      end
      in_valid = 1'b1;
      a        = qa[i][7:0];
      b        = qb[i][7:0];
      in_last  = set_last && (i == qa.size() - 1);
      waits = 0;
      while (!in_ready && waits < 50) begin
        tick();
        waits++;
      end
      if (!in_ready) ok = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output bit got);
    int cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    got = out_valid;
  endtask

  task automatic model(output longint sum, output int cnt);
    sum = 0;
    for (int i = 0; i < qa.size(); i++) sum += longint'(qa[i]) * longint'(qb[i]);
    cnt = qa.size();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 8'd0; b = 8'd0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc_out !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_state in_ready=%b out_valid=%b acc_out=%0d required 1 0 0", in_ready, out_valid, acc_out);
    end
  endtask

  task automatic test_single_beat;
    bit ok;
    qa = '{12}; qb = '{13};
    drive_txn(1'b0, 1'b1, ok);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency out_valid=%b required 1", out_valid);
    end
    n_checks++;
    if (acc_out !== 24'd156 || beat_cnt !== 8'd1 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL single_result acc=%0d cnt=%0d ovf=%b required 156 1 0", acc_out, beat_cnt, overflow);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || acc_out !== 24'd0 || beat_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL handoff out_valid=%b in_ready=%b acc=%0d cnt=%0d required 0 1 0 0", out_valid, in_ready, acc_out, beat_cnt);
    end
  endtask

  task automatic test_stream_hold(input bit bubbles);
    bit ok, got;
    longint s; int c;
    qa = '{3, 7, 255, 0}; qb = '{5, 9, 1, 200};
    model(s, c);
    drive_txn(bubbles, 1'b1, ok);
    wait_out(got);
    n_checks++;
    if (!ok || !got) begin
      n_fail++;
      $display("FAIL stream_timeout accepted=%b out_valid=%b required 1 1", ok, got);
    end
    n_checks++;
    if (acc_out !== 24'(s) || beat_cnt !== 8'(c) || acc_out !== 24'd333) begin
      n_fail++;
      $display("FAIL stream_result bubbles=%b acc=%0d cnt=%0d required 333 4", bubbles, acc_out, beat_cnt);
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); in_last = 1'($urandom);
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_out !== 24'd333 || beat_cnt !== 8'd4) begin
        n_fail++;
        $display("FAIL hold cycle=%0d out_valid=%b in_ready=%b acc=%0d cnt=%0d required 1 0 333 4", k, out_valid, in_ready, acc_out, beat_cnt);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_overflow(input int nb, input int exp_acc, input bit exp_ovf, input int exp_cnt);
    bit ok, got;
    qa.delete(); qb.delete();
    for (int i = 0; i < nb; i++) begin qa.push_back(255); qb.push_back(255); end
    drive_txn(1'b0, 1'b1, ok);
    wait_out(got);
    n_checks++;
    if (!ok || !got || acc_out !== 24'(exp_acc) || overflow !== exp_ovf || beat_cnt !== 8'(exp_cnt)) begin
      n_fail++;
      $display("FAIL overflow_%0d acc=%0d ovf=%b cnt=%0d required %0d %b %0d", nb, acc_out, overflow, beat_cnt, exp_acc, exp_ovf, exp_cnt);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset;
    bit ok, got;
    qa = '{100, 50}; qb = '{7, 3};
    drive_txn(1'b0, 1'b0, ok);
    rst_n = 1'b0;
    #3;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || acc_out !== 24'd0 || beat_cnt !== 8'd0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset in_ready=%b out_valid=%b acc=%0d cnt=%0d ovf=%b required 1 0 0 0 0", in_ready, out_valid, acc_out, beat_cnt, overflow);
    end
    tick();
    rst_n = 1'b1;
    tick();
    qa = '{2}; qb = '{2};
    drive_txn(1'b0, 1'b1, ok);
    wait_out(got);
    n_checks++;
    if (!got || acc_out !== 24'd4 || beat_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL after_reset acc=%0d cnt=%0d required 4 1", acc_out, beat_cnt);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    bit ok, got;
    longint s; int c;
    for (int t = 0; t < 15; t++) begin
      int nb = $urandom_range(1, 10);
      qa.delete(); qb.delete();
      for (int i = 0; i < nb; i++) begin
        qa.push_back($urandom_range(0, 255));
        qb.push_back($urandom_range(0, 255));
      end
      model(s, c);
      drive_txn(1'($urandom), 1'b1, ok);
      wait_out(got);
      n_checks++;
      if (!ok || !got || acc_out !== 24'(s % 64'd16777216) || beat_cnt !== 8'(c % 256)) begin
        n_fail++;
        $display("FAIL rand_txn *ERROR* t=%0d acc=%0d cnt=%0d required %0d %0d", t, acc_out, beat_cnt, s % 64'd16777216, c % 256);
      end
      repeat ($urandom_range(0, 2)) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_beat();
    test_stream_hold(1'b0);
    test_overflow(258, 16776450, 1'b0, 2);
    test_overflow(259, 64259, 1'b1, 3);
    test_stream_hold(1'b1);
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
